mem_sequencer: RTL and testbench
================================

# mem_sequencer

Parametrised memory-access sequencer between the core datapath and a single shared memory bus. It serialises instruction fetches and data loads/stores onto one port, and generates byte strobes and lane alignment. It sign- or zero-extends loads, flags misaligned accesses and bus timeouts, and guarantees each data access is issued exactly once per fetched instruction. This removes the ad-hoc "served data" flag from the datapath.

## Interface
- `DATA_W`, 32: bus and register data width; a power of two, ≥ 32.
- `ADDR_W`, 32: address width.
- `TIMEOUT`, 15: maximum wait cycles for `bus_hit` before aborting; ≥ 1.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_req`  in  1  instruction fetch request, level.
- `fetch_addr`  in  ADDR_W  fetch address, word aligned.
- `fetch_ready`  out  1  one-cycle pulse: `fetch_inst` valid.
- `fetch_inst`  out  DATA_W  fetched instruction, held until the next fetch completes.
- `data_ren`, `data_wen`  in  1 each  data load/store request, level, mutually exclusive.
- `data_addr`  in  ADDR_W  byte address.
- `data_width`  in  2  00 byte, 01 half, 10 word.
- `data_unsigned`  in  1  zero-extend the load.
- `data_store`  in  DATA_W  store value, right-justified.
- `data_done`  out  1  one-cycle pulse: access complete.
- `data_load`  out  DATA_W  extended load value, valid with `data_done`, then held.
- `data_err`  out  1  with `data_done`: misaligned access or timeout.
- `bus_addr`  out  ADDR_W  word-aligned bus address.
- `bus_ren`, `bus_wen`  out  1 each  bus read/write strobes.
- `bus_strb`  out  DATA_W/8  byte enables.
- `bus_wdata`  out  DATA_W  lane-aligned store data.
- `bus_rdata`  in  DATA_W  bus read data.
- `bus_hit`  in  1  bus completion, single cycle.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, FETCH, DATA.
- `served`: internal flag. It is set when a data access completes (OK or error). It is cleared when a fetch completes.
- IDLE, priority order:
  - Pending data request (`data_ren|data_wen`) with `served`=0 goes first.
    - Misaligned request (half at odd address, word with `addr[1:0]`≠0): no bus access; next cycle `data_done`=`data_err`=1, `served`←1.
    - Otherwise → DATA.
  - Else `fetch_req` → FETCH.
  - Else stay in IDLE.
- FETCH, DATA:
  - Bus outputs are registered and stable for the whole state.
  - `bus_hit` → capture `bus_rdata`, return to IDLE, assert the corresponding done/ready pulse.
  - A wait counter increments each cycle without `bus_hit`. When it reaches `TIMEOUT`, drop the strobes and return to IDLE.
    - Data timeout: `data_done`=`data_err`=1, `served`←1.
    - Fetch timeout: `fetch_ready`=1, `fetch_inst`=0 (NOP-safe zero; the decoder traps).
- Strobes, with offset = `addr[log2(DATA_W/8)-1:0]`:
  - byte: 1<<offset.
  - half: 3<<offset.
  - word: 4'hF<<offset.
- `bus_wdata`: `data_store` replicated into every lane of its width.
- Load: `bus_rdata` >> (8·offset), truncated to the width, then sign-extended unless `data_unsigned` or width is word.
- `data_load` is updated only on a completed read.
- Request inputs are sampled in IDLE only. Changes while busy are ignored until the state returns to IDLE.

## Timing
- Reset values:
  - state IDLE, `served`=0.
  - `fetch_inst`=0, `data_load`=0.
  - All pulses, strobes, `bus_addr`, `bus_wdata`, `bus_strb`: 0.
  - `busy`=0.
- Zero-wait bus:
  - Request seen in IDLE at cycle 0.
  - `bus_ren`/`bus_wen` high at cycle 1; `bus_hit` in cycle 1.
  - Done/ready pulse at cycle 2, back in IDLE at cycle 2.
- With N wait cycles, the pulse arrives at cycle 2+N.
- Fetch and data never overlap on the bus. After a pulse, the FSM is in IDLE and may accept a new request in that same cycle.
- `bus_hit` while in IDLE is ignored.
- `bus_hit` in the same cycle the counter reaches `TIMEOUT` counts as a hit.
- `rst` mid-access: return to IDLE next edge, drop strobes, no pulse, `served` cleared.

## Structure
- `rv32ima_pkg` gains:
  - `mem_width_t` (BYTE/HALF/WORD enum).
  - `memseq_state_t` enum.
  - A `MEMSEQ_TIMEOUT_DEF` constant.
- One sub-module, `load_extender`: purely combinational shift, truncate and extend. It is reused later by the pipelined memory stage.

## Test plan
- Fetch, zero-wait: `fetch_addr`=0x100, `bus_rdata`=0x00500093 → `bus_ren` at cycle 1 with `bus_addr`=0x100; `fetch_ready` and `fetch_inst`=0x00500093 at cycle 2.
- Signed byte load at 0x203, `bus_rdata`=0x80AABBCC → `bus_strb`=4'b1000, `data_load`=0xFFFFFF80. Unsigned half at 0x202 → 0x000080AA.
- Store byte 0x5A to 0x201 → `bus_wen`, `bus_strb`=4'b0010, `bus_wdata`=0x5A5A5A5A. `data_ren` held high afterward with no new fetch → no second bus access.
- Simultaneous `fetch_req` and `data_wen` in IDLE → DATA first, FETCH immediately after. A second data access occurs only after the fetch completes.
- Misaligned word at 0x102 → no bus strobe; `data_done`+`data_err` at cycle 1. No `bus_hit` for 15 cycles → `data_err` pulse at cycle 16, strobes low.
- `rst` asserted during a 3-wait DATA access → IDLE next cycle, no `data_done`, strobes 0.

Source files
------------

// File: rtl/rv32ima_pkg.sv
// Shared types and constants for the rv32ima core; this slice holds the
// memory-sequencer definitions.
package rv32ima_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } memseq_state_t;

  localparam int MEMSEQ_TIMEOUT_DEF = 15;

  // The unused encoding 2'b11 is treated as a full word.
  function automatic mem_width_t decode_width(input logic [1:0] code);
    case (code)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_width_t width, input logic [1:0] lo);
    case (width)
      BYTE:    return 1'b0;
      HALF:    return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational load alignment: shift the addressed lane down, truncate to the
// access width and sign- or zero-extend.
module load_extender
  import rv32ima_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]           rdata,
  input  logic [$clog2(DATA_W/8)-1:0] offset,
  input  mem_width_t                  width,
  input  logic                        is_unsigned,
  output logic [DATA_W-1:0]           data
);

  logic [DATA_W-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  // Word loads are never sign-extended, even on buses wider than 32 bits.
  always_comb begin
    data = '0;
    case (width)
      BYTE:    data = is_unsigned ? DATA_W'(shifted[7:0])
                                  : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      HALF:    data = is_unsigned ? DATA_W'(shifted[15:0])
                                  : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      default: data = DATA_W'(shifted[31:0]);
    endcase
  end

endmodule

// File: rtl/mem_sequencer.sv
// Serialises instruction fetches and data loads/stores onto one memory bus,
// issuing each data access once per fetched instruction.
module mem_sequencer
  import rv32ima_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = MEMSEQ_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_req,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic                fetch_ready,
  output logic [DATA_W-1:0]   fetch_inst,
  input  logic                data_ren,
  input  logic                data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [1:0]          data_width,
  input  logic                data_unsigned,
  input  logic [DATA_W-1:0]   data_store,
  output logic                data_done,
  output logic [DATA_W-1:0]   data_load,
  output logic                data_err,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_ren,
  output logic                bus_wen,
  output logic [DATA_W/8-1:0] bus_strb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_hit,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  memseq_state_t    state;
  logic             served;
  logic [CNT_W-1:0] wait_cnt;
  logic [OFF_W-1:0] req_off;
  mem_width_t       req_width;
  logic             req_unsigned;

  mem_width_t        in_width;
  logic [OFF_W-1:0]  in_off;
  logic [STRB_W-1:0] in_strb;
  logic [DATA_W-1:0] in_wdata;
  logic [ADDR_W-1:0] in_word_addr;
  logic [DATA_W-1:0] ext_load;

  assign in_width     = decode_width(data_width);
  assign in_off       = data_addr[OFF_W-1:0];
  assign in_word_addr = {data_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    in_strb = '0;
    case (in_width)
      BYTE:    in_strb = STRB_W'(1) << in_off;
      HALF:    in_strb = STRB_W'(3) << in_off;
      default: in_strb = STRB_W'(4'hF) << in_off;
    endcase
  end

  // Replicate the right-justified store value into every lane of its width.
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
    assign in_wdata[gi*8 +: 8] = (in_width == BYTE) ? data_store[7:0] :
                                 (in_width == HALF) ? data_store[(gi%2)*8 +: 8] :
                                                      data_store[(gi%4)*8 +: 8];
  end

  load_extender #(.DATA_W(DATA_W)) u_load_extender (
    .rdata       (bus_rdata),
    .offset      (req_off),
    .width       (req_width),
    .is_unsigned (req_unsigned),
    .data        (ext_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      served       <= 1'b0;
      wait_cnt     <= '0;
      req_off      <= '0;
      req_width    <= BYTE;
      req_unsigned <= 1'b0;
      fetch_ready  <= 1'b0;
      fetch_inst   <= '0;
      data_done    <= 1'b0;
      data_load    <= '0;
      data_err     <= 1'b0;
      bus_addr     <= '0;
      bus_ren      <= 1'b0;
      bus_wen      <= 1'b0;
      bus_strb     <= '0;
      bus_wdata    <= '0;
    end else begin
      fetch_ready <= 1'b0;
      data_done   <= 1'b0;
      data_err    <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if ((data_ren || data_wen) && !served) begin
            if (is_misaligned(in_width, data_addr[1:0])) begin
              data_done <= 1'b1;
              data_err  <= 1'b1;
              served    <= 1'b1;
            end else begin
              state        <= DATA;
              bus_addr     <= in_word_addr;
              bus_ren      <= data_ren;
              bus_wen      <= data_wen & ~data_ren;
              bus_strb     <= in_strb;
              bus_wdata    <= data_ren ? '0 : in_wdata;
              req_off      <= in_off;
              req_width    <= in_width;
              req_unsigned <= data_unsigned;
            end
          end else if (fetch_req) begin
            state     <= FETCH;
            bus_addr  <= fetch_addr;
            bus_ren   <= 1'b1;
            bus_wen   <= 1'b0;
            bus_strb  <= '1;
            bus_wdata <= '0;
          end
        end
        default: begin
          // A hit in the cycle the counter would expire still counts as a hit.
          if (bus_hit || wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= IDLE;
            bus_addr  <= '0;
            bus_ren   <= 1'b0;
            bus_wen   <= 1'b0;
            bus_strb  <= '0;
            bus_wdata <= '0;
            if (state == FETCH) begin
              fetch_ready <= 1'b1;
              fetch_inst  <= bus_hit ? bus_rdata : '0;
              served      <= 1'b0;
            end else begin
              data_done <= 1'b1;
              data_err  <= ~bus_hit;
              served    <= 1'b1;
              if (bus_hit && bus_ren) data_load <= ext_load;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed vector bench for mem_sequencer with hand-computed expectations.
module tb_mem_sequencer;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;
  localparam int NVEC    = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic [DATA_W-1:0] fetch_inst;
  logic              data_ren;
  logic              data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [1:0]        data_width;
  logic              data_unsigned;
  logic [DATA_W-1:0] data_store;
  logic              data_done;
  logic [DATA_W-1:0] data_load;
  logic              data_err;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_ren;
  logic              bus_wen;
  logic [3:0]        bus_strb;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_hit;
  logic              busy;

  always #5 clk = ~clk;

  mem_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_ready   (fetch_ready),
    .fetch_inst    (fetch_inst),
    .data_ren      (data_ren),
    .data_wen      (data_wen),
    .data_addr     (data_addr),
    .data_width    (data_width),
    .data_unsigned (data_unsigned),
    .data_store    (data_store),
    .data_done     (data_done),
    .data_load     (data_load),
    .data_err      (data_err),
    .bus_addr      (bus_addr),
    .bus_ren       (bus_ren),
    .bus_wen       (bus_wen),
    .bus_strb      (bus_strb),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_hit       (bus_hit),
    .busy          (busy)
  );

  // kind: 0 fetch, 1 load, 2 store; waits >= TIMEOUT means the bus never answers.
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [1:0]  width;
    logic        uns;
    logic [31:0] store;
    logic [31:0] rdata;
    int          waits;
    logic [1:0]  exp_rw;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    int          exp_cycle;
    logic [31:0] exp_result;
    logic        exp_err;
  } vec_t;

  vec_t vecs[NVEC];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit got;
    int seen_cycle;
    logic [31:0] result;
    got = 1'b0;
    seen_cycle = 0;
    fetch_req     = (v.kind == 0);
    data_ren      = (v.kind == 1);
    data_wen      = (v.kind == 2);
    fetch_addr    = v.addr;
    data_addr     = v.addr;
    data_width    = v.width;
    data_unsigned = v.uns;
    data_store    = v.store;
    bus_rdata     = v.rdata;
    for (int c = 1; c <= 25 && !got; c++) begin
      step();
      if (c == 1) begin
        chk({tag, "_bus_rw"},    {bus_ren, bus_wen}, v.exp_rw);
        chk({tag, "_bus_addr"},  bus_addr,  v.exp_addr);
        chk({tag, "_bus_strb"},  bus_strb,  v.exp_strb);
        chk({tag, "_bus_wdata"}, bus_wdata, v.exp_wdata);
      end
      if ((v.kind == 0) ? fetch_ready : data_done) begin
        got = 1'b1;
        seen_cycle = c;
        result = (v.kind == 0) ? fetch_inst : data_load;
        chk({tag, "_pulse_cycle"}, seen_cycle, v.exp_cycle);
        chk({tag, "_result"}, result, v.exp_result);
        if (v.kind != 0) chk({tag, "_err"}, data_err, v.exp_err);
        chk({tag, "_idle_after"}, {bus_ren, bus_wen, busy}, 3'b000);
        fetch_req = 1'b0;
        data_ren  = 1'b0;
        data_wen  = 1'b0;
        bus_hit   = 1'b0;
      end else begin
        bus_hit = (c == 1 + v.waits);
      end
    end
    chk({tag, "_pulse_seen"}, got, 1'b1);
    fetch_req = 1'b0;
    data_ren  = 1'b0;
    data_wen  = 1'b0;
    bus_hit   = 1'b0;
    $display("%s kind=%0d addr=0x%08h pulse_cycle=%0d result=0x%08h err=%0d",
             tag, v.kind, v.addr, seen_cycle, result, data_err);
  endtask

  initial begin
    vec_t fv;
    int bad;

    //          kind addr       w    u     store         rdata         wt  rw     baddr      strb  wdata         cyc result        err
    vecs[0]  = '{0, 32'h100, 2'd0, 1'b0, 32'h0,        32'h00500093, 0,  2'b10, 32'h100, 4'hF, 32'h0,        2,  32'h00500093, 1'b0};
    vecs[1]  = '{1, 32'h203, 2'd0, 1'b0, 32'h0,        32'h80AABBCC, 0,  2'b10, 32'h200, 4'h8, 32'h0,        2,  32'hFFFFFF80, 1'b0};
    vecs[2]  = '{0, 32'h104, 2'd0, 1'b0, 32'h0,        32'h11111111, 2,  2'b10, 32'h104, 4'hF, 32'h0,        4,  32'h11111111, 1'b0};
    vecs[3]  = '{1, 32'h202, 2'd1, 1'b1, 32'h0,        32'h80AABBCC, 1,  2'b10, 32'h200, 4'hC, 32'h0,        3,  32'h000080AA, 1'b0};
    vecs[4]  = '{0, 32'h108, 2'd0, 1'b0, 32'h0,        32'h22222222, 0,  2'b10, 32'h108, 4'hF, 32'h0,        2,  32'h22222222, 1'b0};
    vecs[5]  = '{2, 32'h201, 2'd0, 1'b0, 32'h0000005A, 32'hDEADBEEF, 0,  2'b01, 32'h200, 4'h2, 32'h5A5A5A5A, 2,  32'h000080AA, 1'b0};
    vecs[6]  = '{0, 32'h10C, 2'd0, 1'b0, 32'h0,        32'h33333333, 0,  2'b10, 32'h10C, 4'hF, 32'h0,        2,  32'h33333333, 1'b0};
    vecs[7]  = '{1, 32'h200, 2'd1, 1'b0, 32'h0,        32'h1234F00D, 0,  2'b10, 32'h200, 4'h3, 32'h0,        2,  32'hFFFFF00D, 1'b0};
    vecs[8]  = '{0, 32'h110, 2'd0, 1'b0, 32'h0,        32'h44444444, 1,  2'b10, 32'h110, 4'hF, 32'h0,        3,  32'h44444444, 1'b0};
    vecs[9]  = '{1, 32'h204, 2'd2, 1'b0, 32'h0,        32'h89ABCDEF, 0,  2'b10, 32'h204, 4'hF, 32'h0,        2,  32'h89ABCDEF, 1'b0};
    vecs[10] = '{0, 32'h114, 2'd0, 1'b0, 32'h0,        32'h55555555, 0,  2'b10, 32'h114, 4'hF, 32'h0,        2,  32'h55555555, 1'b0};
    vecs[11] = '{1, 32'h102, 2'd2, 1'b0, 32'h0,        32'hFFFFFFFF, 99, 2'b00, 32'h0,   4'h0, 32'h0,        1,  32'h89ABCDEF, 1'b1};
    vecs[12] = '{0, 32'h118, 2'd0, 1'b0, 32'h0,        32'h66666666, 0,  2'b10, 32'h118, 4'hF, 32'h0,        2,  32'h66666666, 1'b0};
    vecs[13] = '{1, 32'h300, 2'd2, 1'b0, 32'h0,        32'h12345678, 99, 2'b10, 32'h300, 4'hF, 32'h0,        16, 32'h89ABCDEF, 1'b1};
    vecs[14] = '{0, 32'h11C, 2'd0, 1'b0, 32'h0,        32'hABABABAB, 99, 2'b10, 32'h11C, 4'hF, 32'h0,        16, 32'h0,        1'b0};
    vecs[15] = '{1, 32'h201, 2'd0, 1'b1, 32'h0,        32'h0000F700, 14, 2'b10, 32'h200, 4'h2, 32'h0,        16, 32'h000000F7, 1'b0};
    vecs[16] = '{0, 32'h120, 2'd0, 1'b0, 32'h0,        32'h77777777, 0,  2'b10, 32'h120, 4'hF, 32'h0,        2,  32'h77777777, 1'b0};
    vecs[17] = '{2, 32'h202, 2'd1, 1'b0, 32'h1234BEEF, 32'h0,        0,  2'b01, 32'h200, 4'hC, 32'hBEEFBEEF, 2,  32'h000000F7, 1'b0};
    vecs[18] = '{0, 32'h124, 2'd0, 1'b0, 32'h0,        32'h88888888, 0,  2'b10, 32'h124, 4'hF, 32'h0,        2,  32'h88888888, 1'b0};
    vecs[19] = '{2, 32'h203, 2'd1, 1'b0, 32'h0000BEEF, 32'h0,        99, 2'b00, 32'h0,   4'h0, 32'h0,        1,  32'h000000F7, 1'b1};

    rst = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    data_ren = 1'b0; data_wen = 1'b0; data_addr = '0; data_width = 2'd0;
    data_unsigned = 1'b0; data_store = '0; bus_rdata = '0; bus_hit = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_bus", {bus_addr, bus_strb, bus_ren, bus_wen, busy}, 39'h0);
    chk("reset_data", {fetch_inst, data_load}, 64'h0);
    chk("reset_pulses", {fetch_ready, data_done, data_err, bus_wdata}, 35'h0);
    $display("reset checked");

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Data request held after completion, no new fetch: nothing goes to the bus.
    data_ren = 1'b1; data_addr = 32'h200; data_width = 2'd2;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      bad += int'(bus_ren | bus_wen | busy | data_done);
    end
    data_ren = 1'b0;
    chk("held_ren_no_reissue", bad, 0);
    $display("held_ren bad_cycles=%0d", bad);

    // Simultaneous fetch and store: data first, fetch next, data again only after fetch.
    fv = '{0, 32'h130, 2'd0, 1'b0, 32'h0, 32'h13131313, 0, 2'b10, 32'h130, 4'hF, 32'h0, 2, 32'h13131313, 1'b0};
    run_vec(fv, "prio_pre_fetch");
    fetch_req = 1'b1; fetch_addr = 32'h140;
    data_wen = 1'b1; data_addr = 32'h40; data_width = 2'd2; data_store = 32'hCAFEF00D;
    bus_rdata = 32'h99999999;
    step();
    chk("prio_c1_data", {bus_ren, bus_wen, bus_addr}, {2'b01, 32'h40});
    chk("prio_c1_wdata", bus_wdata, 32'hCAFEF00D);
    bus_hit = 1'b1;
    step();
    chk("prio_c2_done", {data_done, data_err, busy, bus_ren}, 4'b1000);
    bus_hit = 1'b0;
    step();
    chk("prio_c3_fetch", {bus_ren, bus_wen, bus_addr}, {2'b10, 32'h140});
    bus_hit = 1'b1;
    step();
    chk("prio_c4_ready", {fetch_ready, fetch_inst}, {1'b1, 32'h99999999});
    bus_hit = 1'b0;
    step();
    chk("prio_c5_data_again", {bus_ren, bus_wen, bus_addr}, {2'b01, 32'h40});
    bus_hit = 1'b1;
    step();
    chk("prio_c6_done", data_done, 1'b1);
    fetch_req = 1'b0; data_wen = 1'b0; bus_hit = 1'b0;
    $display("priority sequence done");

    // Reset during a waiting data access, then a stray hit in IDLE.
    fv = '{0, 32'h150, 2'd0, 1'b0, 32'h0, 32'h15151515, 0, 2'b10, 32'h150, 4'hF, 32'h0, 2, 32'h15151515, 1'b0};
    run_vec(fv, "rst_pre_fetch");
    data_ren = 1'b1; data_addr = 32'h80; data_width = 2'd2; bus_rdata = 32'h0BADCAFE;
    step();
    chk("rst_c1_bus_ren", {bus_ren, busy}, 2'b11);
    step();
    rst = 1'b1;
    step();
    chk("rst_c3_idle", {busy, bus_ren, bus_wen, bus_strb, data_done}, 8'h0);
    chk("rst_c3_load_cleared", data_load, 32'h0);
    rst = 1'b0; data_ren = 1'b0; bus_hit = 1'b1;
    step();
    chk("rst_c4_hit_ignored", {data_done, fetch_ready, busy}, 3'b000);
    bus_hit = 1'b0;
    data_ren = 1'b1; data_addr = 32'h84;
    step();
    chk("rst_served_cleared", {bus_ren, bus_addr}, {1'b1, 32'h84});
    bus_hit = 1'b1;
    step();
    chk("rst_after_load", {data_done, data_err, data_load}, {2'b10, 32'h0BADCAFE});
    data_ren = 1'b0; bus_hit = 1'b0;
    $display("reset sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
